dsp_lane_unpacker: RTL and testbench

- Result-side reader for the lane-split 64-bit DSP multiplier/MAC array.
- Tracks each operation issued to the DSP with a tag pipeline matched to the DSP latency, and captures the packed 64-bit product word when it emerges.
- Buffers captured words in a small FIFO and serialises them into one zero-extended result per enabled lane on a valid/ready stream.
- Sits between the DSP array and the result write-back/accumulation logic; its credit output throttles the operand issuer.

---
 rtl/dsp_lane_unpacker.sv | 178 +++++++++++++++++
 tb/tb_dsp_lane_unpacker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_lane_unpacker.sv
// Result-side reader for the lane-split DSP array: tracks issued ops, captures product words,
// and serialises one zero-extended beat per enabled lane; issue credit keeps the buffer from overflowing.
module dsp_lane_unpacker #(
   parameter int DSP_LATENCY = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int CE_W        = 4
) (
   input  logic            CLK,
   input  logic            SCLR,
   input  logic            issue_valid,
   input  logic [CE_W-1:0] issue_ce,
   input  logic            issue_chain,
   output logic            issue_ready,
   input  logic [63:0]     dsp_p,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [63:0]     out_data,
   output logic [2:0]      out_lane,
   output logic            out_last
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int WORD_W = 64 + CE_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic            tag_vld   [DSP_LATENCY];
   logic [CE_W-1:0] tag_ce    [DSP_LATENCY];
   logic            tag_chain [DSP_LATENCY];

   logic [CNT_W-1:0]  inflight;
   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;

   logic [0:0]      state;
   logic [63:0]     cur_p;
   logic [CE_W-1:0] rem;

   logic            accept, exit_vld, capture, pop, beat_done, fifo_empty;
   logic [WORD_W-1:0] head;
   logic [63:0]     head_p;
   logic [CE_W-1:0] head_ce;
   logic            head_chain;
   logic [2:0]      load_lane, adv_lane;
   logic [CE_W-1:0] load_rem, adv_rem;

   function automatic logic [2:0] lowest(input logic [CE_W-1:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = CE_W - 1; i >= 0; i--)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

   function automatic logic [CE_W-1:0] clear_bit(input logic [CE_W-1:0] m, input logic [2:0] idx);
      return m & ~(CE_W'(1) << idx);
   endfunction

   function automatic logic [63:0] lane_slice(input logic [63:0] p, input logic [2:0] lane);
      logic [63:0] r;
      case (lane)
         3'd0:    r = {56'd0, p[7:0]};
         3'd1:    r = {56'd0, p[15:8]};
         3'd2:    r = {48'd0, p[31:16]};
         3'd3:    r = {32'd0, p[63:32]};
         default: r = p;
      endcase
      return r;
   endfunction

   assign accept   = issue_valid && issue_ready;
   assign exit_vld = tag_vld[DSP_LATENCY-1];
   assign capture  = exit_vld && (tag_chain[DSP_LATENCY-1] || tag_ce[DSP_LATENCY-1] != '0);

   // Credit covers every word that may still land in the buffer, so dsp_p is never dropped.
   assign issue_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;

   always_ff @(posedge CLK) begin
      if (SCLR) begin
         for (int i = 0; i < DSP_LATENCY; i++) begin
            tag_vld[i]   <= 1'b0;
            tag_ce[i]    <= '0;
            tag_chain[i] <= 1'b0;
         end
      end else begin
         tag_vld[0]   <= accept;
         tag_ce[0]    <= accept ? issue_ce : '0;
         tag_chain[0] <= accept && issue_chain;
         for (int i = 1; i < DSP_LATENCY; i++) begin
            tag_vld[i]   <= tag_vld[i-1];
            tag_ce[i]    <= tag_ce[i-1];
            tag_chain[i] <= tag_chain[i-1];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (SCLR) begin
         inflight <= '0;
      end else begin
         case ({accept, exit_vld})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (capture) mem[wr_ptr] <= {dsp_p, tag_ce[DSP_LATENCY-1], tag_chain[DSP_LATENCY-1]};
   end

   always_ff @(posedge CLK) begin
      if (SCLR) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({capture, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign fifo_empty = (fifo_count == '0);
   assign head       = mem[rd_ptr];
   assign head_p     = head[WORD_W-1 -: 64];
   assign head_ce    = head[CE_W:1];
   assign head_chain = head[0];
   assign beat_done  = out_valid && out_ready;
   // Popping on the last accepted beat keeps back-to-back words bubble-free.
   assign pop = !fifo_empty && (state == S_IDLE || (beat_done && out_last));

   always_comb begin
      load_lane = head_chain ? 3'd4 : lowest(head_ce);
      load_rem  = head_chain ? '0 : clear_bit(head_ce, load_lane);
      adv_lane  = lowest(rem);
      adv_rem   = clear_bit(rem, adv_lane);
   end

   always_ff @(posedge CLK) begin
      if (SCLR) begin
         state     <= S_IDLE;
         cur_p     <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_lane  <= '0;
         out_last  <= 1'b0;
      end else if (pop) begin
         state     <= S_EMIT;
         cur_p     <= head_p;
         rem       <= load_rem;
         out_valid <= 1'b1;
         out_data  <= lane_slice(head_p, load_lane);
         out_lane  <= load_lane;
         out_last  <= (load_rem == '0);
      end else if (beat_done) begin
         if (out_last) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
         end else begin
            rem      <= adv_rem;
            out_lane <= adv_lane;
            out_data <= lane_slice(cur_p, adv_lane);
            out_last <= (adv_rem == '0);
         end
      end
   end

endmodule

// File: tb/tb_dsp_lane_unpacker.sv
// Directed and random stimulus for dsp_lane_unpacker, checked against a lane-level beat scoreboard.
module tb_dsp_lane_unpacker;

   localparam int L     = 2;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        SCLR = 1'b1;
   logic        issue_valid = 1'b0;
   logic [3:0]  issue_ce = '0;
   logic        issue_chain = 1'b0;
   logic        issue_ready;
   logic [63:0] dsp_p = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [2:0]  out_lane;
   logic        out_last;

   dsp_lane_unpacker #(.DSP_LATENCY(L), .FIFO_DEPTH(DEPTH), .CE_W(4)) dut (
      .CLK(CLK), .SCLR(SCLR),
      .issue_valid(issue_valid), .issue_ce(issue_ce), .issue_chain(issue_chain),
      .issue_ready(issue_ready), .dsp_p(dsp_p),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_lane(out_lane), .out_last(out_last)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int accepted = 0;

   logic [63:0] q_data[$];
   logic [2:0]  q_lane[$];
   logic        q_last[$];
   logic [63:0] pd [L+1];

   logic        held = 1'b0;
   logic [63:0] held_data;
   logic [2:0]  held_lane;
   logic        held_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference: an accepted op becomes an ordered list of beats, computed straight from the lane map.
   task automatic expect_op(input logic [3:0] ce, input logic ch, input logic [63:0] p);
      int lo [4] = '{0, 8, 16, 32};
      int w  [4] = '{8, 8, 16, 32};
      int top;
      if (ch) begin
         q_data.push_back(p); q_lane.push_back(3'd4); q_last.push_back(1'b1);
      end else begin
         top = -1;
         for (int i = 0; i < 4; i++) if (ce[i]) top = i;
         for (int i = 0; i < 4; i++) begin
            if (ce[i]) begin
               q_data.push_back((p >> lo[i]) & ((64'd1 << w[i]) - 64'd1));
               q_lane.push_back(3'(i));
               q_last.push_back(i == top);
            end
         end
      end
   endtask

   // One cycle: check held-beat stability, drive inputs, score a beat that will handshake, advance.
   task automatic tick(input logic iv, input logic [3:0] ce, input logic ch, input logic ordy,
                       input logic [63:0] p);
      if (held) begin
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_data", out_data, held_data);
         chk("hold_lane", 64'(out_lane), 64'(held_lane));
         chk("hold_last", 64'(out_last), 64'(held_last));
      end
      issue_valid = iv; issue_ce = ce; issue_chain = ch; out_ready = ordy;
      if (iv && issue_ready && !SCLR) begin
         accepted++;
         expect_op(ce, ch, p);
      end
      for (int i = L; i > 0; i--) pd[i] = pd[i-1];
      pd[0] = p;
      dsp_p = pd[L];
      if (out_valid && ordy && !SCLR) begin
         chk("beat_expected", 64'(q_data.size() != 0), 64'd1);
         if (q_data.size() != 0) begin
            chk("beat_data", out_data, q_data.pop_front());
            chk("beat_lane", 64'(out_lane), 64'(q_lane.pop_front()));
            chk("beat_last", 64'(out_last), 64'(q_last.pop_front()));
         end
      end
      held = out_valid && !ordy;
      held_data = out_data; held_lane = out_lane; held_last = out_last;
      @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (q_data.size() != 0 || out_valid); i++) tick(0, 4'h0, 0, 1, rnd64());
      chk("drain_queue_empty", 64'(q_data.size()), 64'd0);
      chk("drain_idle", 64'(out_valid), 64'd0);
   endtask

   initial begin
      int acc0;
      for (int i = 0; i <= L; i++) pd[i] = rnd64();

      // Reset state
      SCLR = 1'b1;
      tick(0, 4'h0, 0, 0, rnd64());
      tick(0, 4'h0, 0, 0, rnd64());
      SCLR = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_lane", 64'(out_lane), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_ready", 64'(issue_ready), 64'd1);

      // All four split lanes, plus first-beat latency
      tick(1, 4'b1111, 0, 1, 64'h89ABCDEF_1234_56_78);
      tick(0, 4'h0, 0, 1, rnd64());
      chk("lat_e1", 64'(out_valid), 64'd0);
      tick(0, 4'h0, 0, 1, rnd64());
      chk("lat_e2", 64'(out_valid), 64'd0);
      tick(0, 4'h0, 0, 1, rnd64());
      chk("lat_e3", 64'(out_valid), 64'd1);
      chk("t1_first_data", out_data, 64'h78);
      chk("t1_first_lane", 64'(out_lane), 64'd0);
      drain();

      // Sparse lanes
      tick(1, 4'b1010, 0, 1, 64'hFFFF0000_AAAA_BB_CC);
      drain();

      // Chained word, then an empty op that must vanish
      tick(1, 4'b1111, 1, 1, 64'h0123456789ABCDEF);
      tick(1, 4'b0000, 0, 1, rnd64());
      drain();

      // Backpressure: buffer fills, one word already sits in the output register
      acc0 = accepted;
      for (int i = 0; i < 8; i++) tick(1, 4'b1111, 0, 0, rnd64());
      chk("stall_accepted", 64'(accepted - acc0), 64'(DEPTH + 1));
      chk("stall_credit_low", 64'(issue_ready), 64'd0);
      for (int i = 0; i < 3; i++) tick(0, 4'h0, 0, 0, rnd64());
      for (int i = 0; i < 100 && q_data.size() != 0; i++) begin
         chk("no_bubble", 64'(out_valid), 64'd1);
         tick(0, 4'h0, 0, 1, rnd64());
      end
      drain();

      // Reset with a stalled beat and two buffered words
      for (int i = 0; i < 3; i++) tick(1, 4'b1111, 0, 0, rnd64());
      for (int i = 0; i < 4; i++) tick(0, 4'h0, 0, 0, rnd64());
      chk("pre_rst_stalled", 64'(out_valid), 64'd1);
      SCLR = 1'b1;
      tick(0, 4'h0, 0, 0, rnd64());
      SCLR = 1'b0;
      held = 1'b0;
      q_data.delete(); q_lane.delete(); q_last.delete();
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ready", 64'(issue_ready), 64'd1);
      for (int i = 0; i < 10; i++) begin
         tick(0, 4'h0, 0, 1, rnd64());
         chk("no_stale_beat", 64'(out_valid), 64'd0);
      end

      // Continuous single-lane stream
      for (int i = 0; i < 40; i++) begin
         chk("stream_credit", 64'(issue_ready), 64'd1);
         tick(1, 4'b0001, 0, 1, rnd64());
         if (i >= 3) begin
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_last", 64'(out_last), 64'd1);
         end
      end
      drain();

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++)
         tick($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, rnd64());
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
